// File: rtl/ppm_tx_pkg.sv
// ----------------------------------------------------------------------------
// ppm_tx_pkg
//   Shared definitions for the PPM transmitter path:
//   - ppm_state_e   : serializer state encoding (IDLE, SEND, GUARD)
//   - ppm_sym_sel   : picks symbol <idx> out of a data word, LSB- or MSB-first
//   - ppm_params_ok : elaboration-time legality check of serializer parameters
//   No ports (package).
// ----------------------------------------------------------------------------
package ppm_tx_pkg;

    // Widest data word the symbol selector supports.
    localparam int unsigned PPM_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2
    } ppm_state_e;

    // Returns the word shifted so that symbol <idx> sits in the low bits; the
    // caller truncates to its symbol width. With msb_first set, symbol 0 is
    // the top slice of a data_w-wide word.
    function automatic logic [PPM_MAX_W-1:0] ppm_sym_sel(
        input logic [PPM_MAX_W-1:0] word,
        input int unsigned          idx,
        input bit                   msb_first,
        input int unsigned          data_w,
        input int unsigned          sym_w
    );
        int unsigned pos;
        pos = msb_first ? (data_w / sym_w - 1 - idx) : idx;
        return word >> (pos * sym_w);
    endfunction

    function automatic bit ppm_params_ok(
        input int unsigned data_w,
        input int unsigned sym_w,
        input int unsigned hold_cyc,
        input int unsigned done_lead,
        input int unsigned guard_cyc
    );
        return (sym_w >= 1) && (data_w >= sym_w) && (data_w <= PPM_MAX_W) &&
               ((data_w % sym_w) == 0) && (hold_cyc >= 2) &&
               (done_lead < hold_cyc) && (guard_cyc >= 1);
    endfunction

endpackage

// File: rtl/ppm_hold_timer.sv
// ----------------------------------------------------------------------------
// ppm_hold_timer
//   Auto-reloading down-counter over CYC clocks. The count starts at CYC-1
//   and wraps back to CYC-1 after reaching 0, so one full period is CYC clocks.
//   Ports:
//     clk        in  clock
//     rst_n      in  asynchronous active-low reset (count -> CYC-1)
//     load_i     in  restart the period (count -> CYC-1)
//     run_i      in  advance the count this clock
//     tc_o       out terminal count: last clock of the period
//     lead_tap_o out high LEAD clocks before the last clock of the period
// ----------------------------------------------------------------------------
module ppm_hold_timer #(
    parameter int unsigned CYC  = 128,
    parameter int unsigned LEAD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic run_i,
    output logic tc_o,
    output logic lead_tap_o
);

    localparam int unsigned CNT_W = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_TOP;
        end else if (run_i) begin
            cnt_d = (cnt_q == '0) ? CNT_TOP : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_TOP;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o       = (cnt_q == '0);
    assign lead_tap_o = (cnt_q == CNT_W'(LEAD));

endmodule

// File: rtl/ppm_symbol_serializer.sv
// ----------------------------------------------------------------------------
// ppm_symbol_serializer
//   Splits a DATA_W word into DATA_W/SYM_W symbols, each held HOLD_CYC clocks,
//   for the PPM modulator. Back-to-back words stream without a bubble; an
//   early word_done pulse lets the upstream reader prefetch.
//   Optional feature macro: PPM_SER_GUARD_EN inserts a GUARD_CYC-clock idle
//   guard after every word (back-to-back accept then happens at the end of
//   the guard instead of at the last symbol).
//   Ports:
//     clk       in   clock
//     rst_n     in   asynchronous active-low reset
//     in_data   in   word to send, sampled on in_valid & in_ready
//     in_valid  in   upstream word available
//     in_ready  out  serializer can accept this clock
//     sym_data  out  current symbol (0 when sym_valid is low)
//     sym_valid out  symbol active
//     sym_first out  first symbol of the word is being held
//     sym_last  out  last symbol of the word is being held
//     word_done out  one-clock early-completion pulse per word
//     busy      out  state is not IDLE
//   All outputs are decoded from registered state only.
// ----------------------------------------------------------------------------
module ppm_symbol_serializer
    import ppm_tx_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SYM_W     = 2,
    parameter int unsigned HOLD_CYC  = 128,
    parameter int unsigned DONE_LEAD = 2,
    parameter int unsigned MSB_FIRST = 0,
    parameter int unsigned GUARD_CYC = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SYM_W-1:0]  sym_data,
    output logic              sym_valid,
    output logic              sym_first,
    output logic              sym_last,
    output logic              word_done,
    output logic              busy
);

    localparam int unsigned NSYM  = DATA_W / SYM_W;
    localparam int unsigned IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);
    localparam bit PARAMS_OK = ppm_params_ok(DATA_W, SYM_W, HOLD_CYC, DONE_LEAD, GUARD_CYC);

    if (!PARAMS_OK) begin : g_param_check
        $error("ppm_symbol_serializer: illegal parameter combination");
    end

    ppm_state_e        state_q;
    logic [IDX_W-1:0]  sym_idx_q;
    logic [DATA_W-1:0] word_q;

    logic send;
    logic last_sym;
    logic accept;
    logic hold_tc;
    logic hold_lead;

    assign send     = (state_q == SEND);
    assign last_sym = (sym_idx_q == LAST_IDX);
    assign accept   = in_valid & in_ready;

    // Symbol hold timer: runs through every SEND clock and wraps on its own,
    // so it is already at the start of a period when the next symbol/word begins.
    ppm_hold_timer #(
        .CYC  (HOLD_CYC),
        .LEAD (DONE_LEAD)
    ) u_hold_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .run_i      (send),
        .tc_o       (hold_tc),
        .lead_tap_o (hold_lead)
    );

`ifdef PPM_SER_GUARD_EN
    logic guard_tc;
    logic guard_lead;
    logic guard_last;

    // With LEAD = 0 both taps mark the final guard clock.
    ppm_hold_timer #(
        .CYC  (GUARD_CYC),
        .LEAD (0)
    ) u_guard_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (send & last_sym & hold_tc),
        .run_i      (state_q == GUARD),
        .tc_o       (guard_tc),
        .lead_tap_o (guard_lead)
    );

    assign guard_last = guard_tc & guard_lead;
`endif

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
`ifdef PPM_SER_GUARD_EN
            SEND:  in_ready = 1'b0;
            GUARD: in_ready = guard_last;
`else
            // Only the final clock of the last symbol can take the next word.
            SEND:  in_ready = last_sym & hold_tc;
`endif
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sym_idx_q <= '0;
            word_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        word_q    <= in_data;
                        sym_idx_q <= '0;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (hold_tc) begin
                        sym_idx_q <= '0;
                        if (!last_sym) begin
                            sym_idx_q <= sym_idx_q + 1'b1;
`ifdef PPM_SER_GUARD_EN
                        end else begin
                            state_q <= GUARD;
                        end
`else
                        end else if (accept) begin
                            word_q <= in_data;
                        end else begin
                            state_q <= IDLE;
                        end
`endif
                    end
                end
`ifdef PPM_SER_GUARD_EN
                GUARD: begin
                    if (guard_last) begin
                        if (accept) begin
                            word_q    <= in_data;
                            sym_idx_q <= '0;
                            state_q   <= SEND;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sym_valid = send;
    assign sym_data  = send ? SYM_W'(ppm_sym_sel(PPM_MAX_W'(word_q), 32'(sym_idx_q),
                                                 (MSB_FIRST != 0), DATA_W, SYM_W))
                            : '0;
    assign sym_first = send & (sym_idx_q == '0);
    assign sym_last  = send & last_sym;
    assign word_done = send & last_sym & hold_lead;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ppm_symbol_serializer.sv
module tb_ppm_symbol_serializer;

    localparam int DATA_W   = 8;
    localparam int SYM_W    = 2;
    localparam int HOLD     = 4;
    localparam int LEAD     = 2;
    localparam int GCYC     = 3;
    localparam int NSYM     = DATA_W / SYM_W;
    localparam int WORD_CYC = NSYM * HOLD;
`ifdef PPM_SER_GUARD_EN
    localparam int GAP   = GCYC;
    localparam bit GMODE = 1'b1;
`else
    localparam int GAP   = 0;
    localparam bit GMODE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;

    logic              r0_ready, r0_valid, r0_first, r0_last, r0_done, r0_busy;
    logic [SYM_W-1:0]  r0_data;
    logic              r1_ready, r1_valid, r1_first, r1_last, r1_done, r1_busy;
    logic [SYM_W-1:0]  r1_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ppm_symbol_serializer #(
        .DATA_W(DATA_W), .SYM_W(SYM_W), .HOLD_CYC(HOLD), .DONE_LEAD(LEAD),
        .MSB_FIRST(0), .GUARD_CYC(GCYC)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r0_ready), .sym_data(r0_data), .sym_valid(r0_valid),
        .sym_first(r0_first), .sym_last(r0_last), .word_done(r0_done), .busy(r0_busy)
    );

    ppm_symbol_serializer #(
        .DATA_W(DATA_W), .SYM_W(SYM_W), .HOLD_CYC(HOLD), .DONE_LEAD(LEAD),
        .MSB_FIRST(1), .GUARD_CYC(GCYC)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r1_ready), .sym_data(r1_data), .sym_valid(r1_valid),
        .sym_first(r1_first), .sym_last(r1_last), .word_done(r1_done), .busy(r1_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: word timeline ----------------
    // mode 0 = idle, 1 = sending (t = clock within the word), 2 = guard (g = guard clock)
    int          m_mode;
    int          m_t;
    int          m_g;
    logic [7:0]  m_w;
    logic        m_ready;

    function automatic logic [31:0] sym_of(input logic [7:0] w, input int idx, input bit msb);
        int p;
        p = msb ? (NSYM - 1 - idx) : idx;
        return 32'((w >> (p * SYM_W)) & 8'h03);
    endfunction

    assign m_ready = (m_mode == 0) ||
                     (m_mode == 1 && !GMODE && m_t == WORD_CYC - 1) ||
                     (m_mode == 2 && m_g == GCYC - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_t <= 0; m_g <= 0; m_w <= 8'h00;
        end else begin
            case (m_mode)
                0: if (in_valid && m_ready) begin
                    m_mode <= 1; m_t <= 0; m_w <= in_data;
                end
                1: if (m_t == WORD_CYC - 1) begin
                    if (GMODE) begin
                        m_mode <= 2; m_g <= 0;
                    end else if (in_valid) begin
                        m_t <= 0; m_w <= in_data;
                    end else begin
                        m_mode <= 0;
                    end
                end else begin
                    m_t <= m_t + 1;
                end
                default: if (m_g == GCYC - 1) begin
                    if (in_valid) begin
                        m_mode <= 1; m_t <= 0; m_w <= in_data;
                    end else begin
                        m_mode <= 0;
                    end
                end else begin
                    m_g <= m_g + 1;
                end
            endcase
        end
    end

    logic        m_valid;
    logic [31:0] m_data0, m_data1;
    logic        m_first, m_last, m_done;
    assign m_valid = (m_mode == 1);
    assign m_data0 = m_valid ? sym_of(m_w, m_t / HOLD, 1'b0) : 32'd0;
    assign m_data1 = m_valid ? sym_of(m_w, m_t / HOLD, 1'b1) : 32'd0;
    assign m_first = m_valid && (m_t < HOLD);
    assign m_last  = m_valid && (m_t >= WORD_CYC - HOLD);
    assign m_done  = m_valid && (m_t == WORD_CYC - 1 - LEAD);

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        chk("m_ready0", 32'(r0_ready), 32'(m_ready));
        chk("m_valid0", 32'(r0_valid), 32'(m_valid));
        chk("m_data0",  32'(r0_data),  m_data0);
        chk("m_first0", 32'(r0_first), 32'(m_first));
        chk("m_last0",  32'(r0_last),  32'(m_last));
        chk("m_done0",  32'(r0_done),  32'(m_done));
        chk("m_busy0",  32'(r0_busy),  32'(m_mode != 0));
        chk("m_ready1", 32'(r1_ready), 32'(m_ready));
        chk("m_valid1", 32'(r1_valid), 32'(m_valid));
        chk("m_data1",  32'(r1_data),  m_data1);
        chk("m_first1", 32'(r1_first), 32'(m_first));
        chk("m_last1",  32'(r1_last),  32'(m_last));
        chk("m_done1",  32'(r1_done),  32'(m_done));
    end

    // ---------------- directed stimulus with literal expectations ----------------
    // 0xB4 LSB-first 0,1,3,2 / MSB-first 2,3,1,0; 0x1E LSB-first 2,3,1,0 / MSB-first 0,1,3,2
    logic [31:0] b4_lsb [0:3] = '{32'd0, 32'd1, 32'd3, 32'd2};
    logic [31:0] b4_msb [0:3] = '{32'd2, 32'd3, 32'd1, 32'd0};
    logic [31:0] e1_lsb [0:3] = '{32'd2, 32'd3, 32'd1, 32'd0};
    logic [31:0] e1_msb [0:3] = '{32'd0, 32'd1, 32'd3, 32'd2};
    logic [7:0]  stream [0:3] = '{8'h00, 8'hFF, 8'h5A, 8'hC3};

    task automatic wait_idle(input string name);
        for (int n = 0; n < 100; n++) begin
            if (!r0_busy && !r1_busy) break;
            @(negedge clk);
        end
        chk(name, 32'(r0_busy | r1_busy), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int valid_cnt;
        int k;
        bit w2;
        bit gap;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(r0_ready), 32'd1);
        chk("rst_valid", 32'(r0_valid), 32'd0);
        chk("rst_busy",  32'(r0_busy),  32'd0);
        chk("rst_data",  32'(r1_data),  32'd0);
        rst_n = 1'b1;

        // single word 0xB4
        @(negedge clk); in_data = 8'hB4; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0; in_data = 8'h00;
        for (int i = 0; i < 16; i++) begin
            chk("t1_sym_lsb",   32'(r0_data), b4_lsb[2'(i / 4)]);
            chk("t1_sym_msb",   32'(r1_data), b4_msb[2'(i / 4)]);
            chk("t1_model_lsb", m_data0,      b4_lsb[2'(i / 4)]);
            chk("t1_valid",     32'(r0_valid), 32'd1);
            chk("t1_first",     32'(r1_first), 32'(i < 4));
            chk("t1_last",      32'(r1_last),  32'(i >= 12));
            chk("t1_done",      32'(r0_done),  32'(i == 13));
            @(negedge clk);
        end
        chk("t1_end_valid", 32'(r0_valid), 32'd0);
        chk("t1_end_ready", 32'(r0_ready), 32'(GAP == 0));
        wait_idle("t1_idle");

        // back-to-back 0xB4, 0x1E with in_valid held
        @(negedge clk); in_data = 8'hB4; in_valid = 1'b1;
        @(negedge clk); in_data = 8'h1E;
        done_cnt = 0; valid_cnt = 0;
        for (int i = 0; i < 32 + GAP; i++) begin
            w2  = (i >= 16 + GAP);
            gap = (i >= 16) && (i < 16 + GAP);
            k   = w2 ? (i - 16 - GAP) : i;
            chk("t3_valid", 32'(r0_valid), 32'(!gap));
            if (!gap) begin
                chk("t3_sym_lsb", 32'(r0_data), w2 ? e1_lsb[2'(k / 4)] : b4_lsb[2'(k / 4)]);
                chk("t3_sym_msb", 32'(r1_data), w2 ? e1_msb[2'(k / 4)] : b4_msb[2'(k / 4)]);
                chk("t3_done",    32'(r0_done), 32'(k == 13));
            end else begin
                chk("t3_gap_data", 32'(r0_data), 32'd0);
                chk("t3_gap_busy", 32'(r0_busy), 32'd1);
            end
            chk("t3_ready", 32'(r0_ready), 32'((i == 15 + GAP) || (GAP == 0 && i == 31)));
            if (r0_done) done_cnt++;
            if (r0_valid) valid_cnt++;
            if (i == 16 + GAP) in_valid = 1'b0;
            @(negedge clk);
        end
        chk("t3_done_cnt",  32'(done_cnt),  32'd2);
        chk("t3_valid_cnt", 32'(valid_cnt), 32'd32);
        wait_idle("t3_idle");

        // new word offered mid-word is held off until the legal accept clock
        @(negedge clk); in_data = 8'hB4; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 16 + GAP; i++) begin
            if (i < 16) chk("t4_sym_lsb", 32'(r0_data), b4_lsb[2'(i / 4)]);
            chk("t4_ready", 32'(r0_ready), 32'(i == 15 + GAP));
            if (i == 5) begin in_data = 8'h1E; in_valid = 1'b1; end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("t4_new_sym",   32'(r0_data),  32'd2);
        chk("t4_new_first", 32'(r0_first), 32'd1);
        wait_idle("t4_idle");

        // asynchronous reset in the middle of symbol 2
        @(negedge clk); in_data = 8'hB4; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        chk("t5_pre_sym", 32'(r0_data), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(r0_valid), 32'd0);
        chk("t5_data",  32'(r0_data),  32'd0);
        chk("t5_done",  32'(r0_done),  32'd0);
        chk("t5_ready", 32'(r0_ready), 32'd1);
        chk("t5_busy",  32'(r1_busy),  32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); in_data = 8'h1E; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        chk("t5_restart_lsb",   32'(r0_data),  32'd2);
        chk("t5_restart_msb",   32'(r1_data),  32'd0);
        chk("t5_restart_first", 32'(r0_first), 32'd1);
        wait_idle("t5_idle");

        // streamed words, next word presented as soon as the previous is taken
        for (int j = 0; j < 4; j++) begin
            in_data = stream[2'(j)]; in_valid = 1'b1;
            for (int n = 0; n < 100; n++) begin
                if (r0_ready) break;
                @(negedge clk);
            end
            chk("t6_ready_seen", 32'(r0_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_idle("t6_idle");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
